// File: rtl/tpsram_pipe_if.sv
// Write/read port bundle of the two-port SRAM. The master drives both request
// ports; the slave (the RAM) returns read data and its valid strobe.
interface tpsram_pipe_if #(
    parameter int DATA_WIDTH = 32'sd8,
    parameter int ADDR_WIDTH = 32'sd14
) ();
    logic                      W_EN;
    logic [ADDR_WIDTH-1:0]     W_ADDR;
    logic [DATA_WIDTH-1:0]     W_DATA;
    logic [DATA_WIDTH/8-1:0]   W_BE;
    logic                      R_EN;
    logic [ADDR_WIDTH-1:0]     R_ADDR;
    logic [DATA_WIDTH-1:0]     R_DATA;
    logic                      R_VALID;

    modport master (
        output W_EN, W_ADDR, W_DATA, W_BE, R_EN, R_ADDR,
        input  R_DATA, R_VALID
    );

    modport slave (
        input  W_EN, W_ADDR, W_DATA, W_BE, R_EN, R_ADDR,
        output R_DATA, R_VALID
    );
endinterface

// File: rtl/tpsram_pipe.sv
// Parametrised two-port synchronous SRAM: byte-masked write port, read port with
// a 1- or 2-stage output pipeline, selectable collision behaviour and valid strobe.
module tpsram_pipe #(
    parameter int DATA_WIDTH     = 32'sd8,
    parameter int ADDR_WIDTH     = 32'sd14,
    parameter int DEPTH          = 32'sd2 ** ADDR_WIDTH,
    parameter int RD_LATENCY     = 32'sd1,
    parameter int COLLISION_MODE = 32'sd0
) (
    input  logic         CLK,
    input  logic         RESET,
    tpsram_pipe_if.slave mem_if
);
    localparam int                BW         = 32'sd8;
    localparam int                NB         = DATA_WIDTH / BW;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                WRITE_THRU = (COLLISION_MODE == 32'sd1);

    if ((DATA_WIDTH < BW) || ((DATA_WIDTH % BW) != 32'sd0)) begin : g_bad_width
        $fatal(1, "tpsram_pipe: DATA_WIDTH must be a positive multiple of 8");
    end
    if ((RD_LATENCY != 32'sd1) && (RD_LATENCY != 32'sd2)) begin : g_bad_latency
        $fatal(1, "tpsram_pipe: RD_LATENCY must be 1 or 2");
    end
    if ((COLLISION_MODE != 32'sd0) && (COLLISION_MODE != 32'sd1)) begin : g_bad_mode
        $fatal(1, "tpsram_pipe: COLLISION_MODE must be 0 or 1");
    end
    if ((DEPTH < 32'sd1) || (DEPTH > (32'sd2 ** ADDR_WIDTH))) begin : g_bad_depth
        $fatal(1, "tpsram_pipe: DEPTH must be in 1..2**ADDR_WIDTH");
    end

    // Storage is deliberately never reset so it maps onto a RAM macro.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  w_ok_s;
    logic                  r_ok_s;
    logic                  coll_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] rd_next_s;
    logic [DATA_WIDTH-1:0] s1_data_r;
    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic                  out_valid_s;

    assign w_ok_s = ({1'b0, mem_if.W_ADDR} < DEPTH_C);
    assign r_ok_s = ({1'b0, mem_if.R_ADDR} < DEPTH_C);
    assign coll_s = mem_if.W_EN & mem_if.R_EN & w_ok_s & r_ok_s
                  & (mem_if.W_ADDR == mem_if.R_ADDR);

    // Byte-masked write port; out-of-range and reset-cycle writes are dropped
    always_ff @(posedge CLK) begin
        if (!RESET && mem_if.W_EN && w_ok_s) begin
            for (int b = 32'sd0; b < NB; b++) begin
                if (mem_if.W_BE[b]) begin
                    mem_r[mem_if.W_ADDR][b*BW +: BW] <= mem_if.W_DATA[b*BW +: BW];
                end
            end
        end
    end

    // Read word selection with optional same-edge byte merge of the write data
    always_comb begin
        rd_word_s = '0;
        rd_next_s = '0;
        if (r_ok_s) begin
            rd_word_s = mem_r[mem_if.R_ADDR];
        end else begin
            rd_word_s = '0;
        end
        if (WRITE_THRU && coll_s) begin
            for (int b = 32'sd0; b < NB; b++) begin
                if (mem_if.W_BE[b]) begin
                    rd_next_s[b*BW +: BW] = mem_if.W_DATA[b*BW +: BW];
                end else begin
                    rd_next_s[b*BW +: BW] = rd_word_s[b*BW +: BW];
                end
            end
        end else begin
            rd_next_s = rd_word_s;
        end
    end

    // Stage 1: capture launched read; holds data between reads
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= mem_if.R_EN;
            if (mem_if.R_EN) begin
                s1_data_r <= rd_next_s;
            end
        end
    end

    if (RD_LATENCY == 32'sd2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_r;
        logic                  s2_valid_r;

        // Stage 2: loads only when stage 1 carries a valid result
        always_ff @(posedge CLK) begin
            if (RESET) begin
                s2_valid_r <= 1'b0;
                s2_data_r  <= '0;
            end else begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= s1_data_r;
                end
            end
        end

        assign out_data_s  = s2_data_r;
        assign out_valid_s = s2_valid_r;
    end else begin : g_lat1
        assign out_data_s  = s1_data_r;
        assign out_valid_s = s1_valid_r;
    end

    assign mem_if.R_DATA  = out_data_s;
    assign mem_if.R_VALID = out_valid_s;
endmodule

// File: tb/tb_tpsram_pipe.sv
// Bench for tpsram_pipe: an 8-bit/RD_LATENCY=1/read-first instance and a
// 32-bit/DEPTH=1000/RD_LATENCY=2/write-through instance, checked by scoreboards.
module tb_tpsram_pipe;
    logic CLK = 1'b0;
    logic RESET;
    int   cyc_r = 0;
    int   checks_r = 0;
    int   errors_r = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] mdl_a [16];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_r <= cyc_r + 1;

    tpsram_pipe_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(14)) bus_a ();
    tpsram_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_b ();

    tpsram_pipe #(
        .DATA_WIDTH(8), .ADDR_WIDTH(14), .DEPTH(16384),
        .RD_LATENCY(1), .COLLISION_MODE(0)
    ) u_dut_a (
        .CLK(CLK), .RESET(RESET), .mem_if(bus_a)
    );

    tpsram_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000),
        .RD_LATENCY(2), .COLLISION_MODE(1)
    ) u_dut_b (
        .CLK(CLK), .RESET(RESET), .mem_if(bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_r);
        end
    endtask

    task automatic drive_a(input logic we, input logic [13:0] wa, input logic [7:0] wd,
                           input logic wbe, input logic re, input logic [13:0] ra,
                           input logic [7:0] exp);
        exp_t e;
        @(posedge CLK);
        #1;
        bus_a.W_EN   = we;
        bus_a.W_ADDR = wa;
        bus_a.W_DATA = wd;
        bus_a.W_BE   = wbe;
        bus_a.R_EN   = re;
        bus_a.R_ADDR = ra;
        if (re) begin
            e.data = {24'd0, exp};
            e.cyc  = cyc_r + 1;
            q_a.push_back(e);
        end
    endtask

    task automatic drive_b(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                           input logic [3:0] wbe, input logic re, input logic [9:0] ra,
                           input bit expect_rd, input logic [31:0] exp);
        exp_t e;
        @(posedge CLK);
        #1;
        bus_b.W_EN   = we;
        bus_b.W_ADDR = wa;
        bus_b.W_DATA = wd;
        bus_b.W_BE   = wbe;
        bus_b.R_EN   = re;
        bus_b.R_ADDR = ra;
        if (re && expect_rd) begin
            e.data = exp;
            e.cyc  = cyc_r + 2;
            q_b.push_back(e);
        end
    endtask

    // Output monitors: every R_VALID must match the oldest expectation at its exact cycle
    always @(negedge CLK) begin
        exp_t e;
        if (bus_a.R_VALID === 1'b1) begin
            if (q_a.size() == 0) begin
                check_val("a_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check_val("a_rdata", {24'd0, bus_a.R_DATA}, e.data);
                check_val("a_valid_cycle", cyc_r, e.cyc);
            end
        end else if (q_a.size() != 0 && q_a[0].cyc < cyc_r) begin
            e = q_a.pop_front();
            check_val("a_missing_valid", 32'd0, 32'd1);
        end
        if (bus_b.R_VALID === 1'b1) begin
            if (q_b.size() == 0) begin
                check_val("b_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check_val("b_rdata", bus_b.R_DATA, e.data);
                check_val("b_valid_cycle", cyc_r, e.cyc);
            end
        end else if (q_b.size() != 0 && q_b[0].cyc < cyc_r) begin
            e = q_b.pop_front();
            check_val("b_missing_valid", 32'd0, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic        re;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [7:0]  wd;

        RESET = 1'b1;
        bus_a.W_EN = 1'b0; bus_a.W_ADDR = '0; bus_a.W_DATA = '0; bus_a.W_BE = '0;
        bus_a.R_EN = 1'b0; bus_a.R_ADDR = '0;
        bus_b.W_EN = 1'b0; bus_b.W_ADDR = '0; bus_b.W_DATA = '0; bus_b.W_BE = '0;
        bus_b.R_EN = 1'b0; bus_b.R_ADDR = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("a_reset_rdata",  {24'd0, bus_a.R_DATA}, 32'h0);
        check_val("a_reset_rvalid", {31'd0, bus_a.R_VALID}, 32'h0);
        check_val("b_reset_rdata",  bus_b.R_DATA, 32'h0);
        check_val("b_reset_rvalid", {31'd0, bus_b.R_VALID}, 32'h0);
        RESET = 1'b0;

        // Instance A: basic write/read, W_BE=0, read-first collision, hold
        drive_a(1'b1, 14'h0003, 8'hA5, 1'b1, 1'b0, 14'h0, 8'h00);
        drive_a(1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0003, 8'hA5);
        drive_a(1'b1, 14'h0003, 8'h33, 1'b0, 1'b0, 14'h0, 8'h00);
        drive_a(1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0003, 8'hA5);
        drive_a(1'b1, 14'h0010, 8'h00, 1'b1, 1'b0, 14'h0, 8'h00);
        drive_a(1'b1, 14'h0010, 8'h7E, 1'b1, 1'b1, 14'h0010, 8'h00);
        drive_a(1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0010, 8'h7E);
        repeat (3) drive_a(1'b0, 14'h0, 8'h00, 1'b1, 1'b0, 14'h0, 8'h00);
        check_val("a_hold_rdata",  {24'd0, bus_a.R_DATA}, 32'h7E);
        check_val("a_hold_rvalid", {31'd0, bus_a.R_VALID}, 32'h0);

        // Instance A: random traffic against a read-first reference model
        for (int i = 0; i < 16; i++) begin
            mdl_a[i] = 8'(i) ^ 8'h5A;
            drive_a(1'b1, 14'(i), mdl_a[i], 1'b1, 1'b0, 14'h0, 8'h00);
        end
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            drive_a(we, {10'd0, wa}, wd, 1'b1, re, {10'd0, ra}, mdl_a[ra]);
            if (we) mdl_a[wa] = wd;
        end
        drive_a(1'b0, 14'h0, 8'h00, 1'b1, 1'b0, 14'h0, 8'h00);

        // Instance B: byte enables and write-through collisions
        drive_b(1'b1, 10'd5, 32'h11223344, 4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b1, 10'd5, 32'hAABBCCDD, 4'h5, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b0, 10'd0, 32'h0,        4'h0, 1'b1, 10'd5, 1'b1, 32'h11BB33DD);
        drive_b(1'b1, 10'd5, 32'hFFFFFFFF, 4'h2, 1'b1, 10'd5, 1'b1, 32'h11BBFFDD);
        drive_b(1'b1, 10'h10, 32'h0,       4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b1, 10'h10, 32'h7E,      4'hF, 1'b1, 10'h10, 1'b1, 32'h7E);

        // Instance B: back-to-back reads, later write must not disturb a launched read
        for (int i = 0; i < 8; i++) begin
            drive_b(1'b1, 10'(i), 32'(i), 4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            drive_b((i == 2), 10'd1, 32'hFF, 4'hF, 1'b1, 10'(i), 1'b1, 32'(i));
        end
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1, 1'b1, 32'hFF);

        // Instance B: out-of-range write dropped, out-of-range read returns zero
        drive_b(1'b1, 10'd10,   32'h0000000A, 4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b1, 10'd1010, 32'h55,       4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1010, 1'b1, 32'h0);
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd10,   1'b1, 32'h0000000A);

        // Instance B: reset one edge after a read discards it and blocks its write
        drive_b(1'b1, 10'd20, 32'hCAFE0001, 4'hF, 1'b0, 10'd0, 1'b0, 32'h0);
        repeat (4) drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b0, 32'h0);
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd20, 1'b0, 32'h0);
        drive_b(1'b1, 10'd20, 32'hDEAD0000, 4'hF, 1'b1, 10'd7, 1'b0, 32'h0);
        RESET = 1'b1;
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b0, 32'h0);
        RESET = 1'b0;
        repeat (3) drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b0, 32'h0);
        check_val("b_after_reset_rdata", bus_b.R_DATA, 32'h0);
        check_val("a_after_reset_rdata", {24'd0, bus_a.R_DATA}, 32'h0);
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd20, 1'b1, 32'hCAFE0001);
        drive_b(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b0, 32'h0);

        repeat (6) @(posedge CLK);
        #1;
        check_val("a_queue_drained", 32'(q_a.size()), 32'd0);
        check_val("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end
endmodule
